uart_dump_ctrl: RTL and testbench

//  Readout scheduler for the code-density histogram RAM. On a start pulse it walks RAM addresses
//  0..NUM_WORDS-1 and, for each word, sends a 4-byte record {addr_hi, addr_lo, data_hi, data_lo}
//  to the byte-level UART transmitter through a valid/ready handshake. It owns the RAM read port

---
 rtl/uart_dump_pkg.sv | 28 ++
 rtl/uart_dump_csum.sv | 21 ++
 rtl/uart_dump_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_dump_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dump_pkg.sv
// Shared definitions for the histogram RAM dump controller: FSM encoding, record layout, checksum seed.
package uart_dump_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] CSUM    = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  localparam int         RECORD_BYTES = 4;
  localparam logic [7:0] CSUM_INIT    = 8'h00;

  // Record byte order on the wire: address MSB, address LSB, data MSB, data LSB.
  function automatic logic [7:0] record_byte(input logic [1:0]  idx,
                                             input logic [15:0] addr16,
                                             input logic [15:0] data16);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr16[15:8];
      2'd1:    b = addr16[7:0];
      2'd2:    b = data16[15:8];
      default: b = data16[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_dump_csum.sv
// Running XOR of the record bytes handed to the UART; present only when UART_DUMP_CSUM_EN is defined.
module uart_dump_csum
  import uart_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= CSUM_INIT;
    end else if (en) begin
      sum <= sum ^ byte_in;
    end
  end

endmodule

// File: rtl/uart_dump_ctrl.sv
// Walks the histogram RAM and streams one 4-byte {addr, data} record per word to the UART.
// Optional trailing XOR checksum byte when UART_DUMP_CSUM_EN is defined.
module uart_dump_ctrl
  import uart_dump_pkg::*;
#(
  parameter int WIDTH_DATA  = 16,
  parameter int LENGTH_ADDR = 10,
  parameter int NUM_WORDS   = 1024,
  parameter int RAM_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dump_start,
  input  logic                   abort,
  output logic                   ram_rd_en,
  output logic [LENGTH_ADDR-1:0] ram_addr,
  input  logic [WIDTH_DATA-1:0]  ram_dout,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  // Handshake: a byte moves on every cycle with tx_valid & tx_ready. While tx_valid is high and
  // tx_ready is low, tx_byte and tx_valid hold; tx_valid never drops without a transfer except on rst.

  localparam logic [LENGTH_ADDR-1:0] LAST_ADDR = LENGTH_ADDR'(NUM_WORDS - 1);
  localparam logic [2:0]             LAT_LAST  = 3'(RAM_LAT - 1);

  logic [2:0]             state;
  logic [LENGTH_ADDR-1:0] addr;
  logic [WIDTH_DATA-1:0]  word_q;
  logic [1:0]             idx;
  logic [2:0]             lat_cnt;
  logic                   xfer;
  logic [15:0]            addr16;
  logic [15:0]            data16;

  assign xfer   = tx_valid & tx_ready;
  assign addr16 = 16'(addr);
  assign data16 = 16'(word_q);

`ifdef UART_DUMP_CSUM_EN
  logic [7:0] csum;

  uart_dump_csum u_csum (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == IDLE) && dump_start),
    .en      ((state == SEND) && xfer),
    .byte_in (tx_byte),
    .sum     (csum)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      word_q  <= '0;
      idx     <= 2'd0;
      lat_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state <= RD_REQ;
            addr  <= '0;
            idx   <= 2'd0;
          end
        end
        RD_REQ: begin
          if (abort) begin
            state <= IDLE;
            addr  <= '0;
          end else begin
            state   <= RD_WAIT;
            lat_cnt <= 3'd0;
          end
        end
        RD_WAIT: begin
          if (abort) begin
            state <= IDLE;
            addr  <= '0;
          end else if (lat_cnt == LAT_LAST) begin
            word_q <= ram_dout;
            idx    <= 2'd0;
            state  <= SEND;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        SEND: begin
          // Abort only takes effect on a byte boundary, so the byte on the wire always completes.
          if (xfer) begin
            if (abort) begin
              state <= IDLE;
              addr  <= '0;
              idx   <= 2'd0;
            end else if (idx == 2'(RECORD_BYTES - 1)) begin
              idx <= 2'd0;
              if (addr == LAST_ADDR) begin
`ifdef UART_DUMP_CSUM_EN
                state <= CSUM;
`else
                state <= FIN;
`endif
              end else begin
                addr  <= addr + LENGTH_ADDR'(1);
                state <= RD_REQ;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
`ifdef UART_DUMP_CSUM_EN
        CSUM: begin
          if (xfer) begin
            state <= abort ? IDLE : FIN;
            if (abort) addr <= '0;
          end
        end
`endif
        FIN: begin
          state <= IDLE;
          addr  <= '0;
        end
        default: begin
          state <= IDLE;
          addr  <= '0;
        end
      endcase
    end
  end

  assign ram_rd_en = (state == RD_REQ);
  assign ram_addr  = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign dbg_state = state;

`ifdef UART_DUMP_CSUM_EN
  assign tx_valid = (state == SEND) || (state == CSUM);
`else
  assign tx_valid = (state == SEND);
`endif

  always_comb begin
    tx_byte = 8'h00;
    if (state == SEND) begin
      tx_byte = record_byte(idx, addr16, data16);
    end
`ifdef UART_DUMP_CSUM_EN
    else if (state == CSUM) begin
      tx_byte = csum;
    end
`endif
  end

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Bench for uart_dump_ctrl: a 4-word dump (RAM_LAT=1) and a 1024-word dump (RAM_LAT=3) checked
// byte-by-byte against an expected queue; follows UART_DUMP_CSUM_EN for the trailing checksum byte.
module tb_uart_dump_ctrl;

`ifdef UART_DUMP_CSUM_EN
  localparam int CS_BYTES = 1;
`else
  localparam int CS_BYTES = 0;
`endif

  typedef struct {
    int ready_mode;   // 0: tx_ready always high, 1: high about one cycle in three
    int abort_at;     // byte index stalled on when abort is raised, -1 for none
    int exp_done;     // done pulses expected
    int exp_nbytes;   // bytes expected to be transferred
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 words, latency 1 ----------------
  logic        a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b1;
  logic        a_rd_en, a_valid, a_busy, a_done;
  logic [2:0]  a_addr;
  logic [15:0] a_dout = 16'h0000;
  logic [7:0]  a_byte;
  logic [2:0]  a_state;

  uart_dump_ctrl #(.WIDTH_DATA(16), .LENGTH_ADDR(3), .NUM_WORDS(4), .RAM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .dump_start(a_start), .abort(a_abort),
    .ram_rd_en(a_rd_en), .ram_addr(a_addr), .ram_dout(a_dout),
    .tx_byte(a_byte), .tx_valid(a_valid), .tx_ready(a_ready),
    .busy(a_busy), .done(a_done), .dbg_state(a_state)
  );

  always @(posedge clk) if (a_rd_en) a_dout <= 16'hA500 + 16'(a_addr);

  // ---------------- DUT B: 1024 words, latency 3 ----------------
  logic        b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
  logic        b_rd_en, b_valid, b_busy, b_done;
  logic [9:0]  b_addr;
  logic [15:0] b_p1 = 16'h0, b_p2 = 16'h0, b_dout = 16'h0;
  logic [7:0]  b_byte;
  logic [2:0]  b_state;

  uart_dump_ctrl #(.WIDTH_DATA(16), .LENGTH_ADDR(10), .NUM_WORDS(1024), .RAM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .dump_start(b_start), .abort(b_abort),
    .ram_rd_en(b_rd_en), .ram_addr(b_addr), .ram_dout(b_dout),
    .tx_byte(b_byte), .tx_valid(b_valid), .tx_ready(b_ready),
    .busy(b_busy), .done(b_done), .dbg_state(b_state)
  );

  always @(posedge clk) begin
    if (b_rd_en) b_p1 <= 16'hA500 + 16'(b_addr);
    b_p2   <= b_p1;
    b_dout <= b_p2;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int a_bytes = 0, b_bytes = 0, a_done_cnt = 0, b_done_cnt = 0;
  int a_first_rd = -1, a_first_valid = -1, b_first_valid = -1;
  logic a_stall_prev = 1'b0, b_stall_prev = 1'b0;
  logic [7:0] a_hold = 8'h00, b_hold = 8'h00;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Builds the byte stream of a full dump and queues its first 'limit' bytes.
  task automatic push_dump(input bit which, input int nwords, input int limit);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    logic [15:0] d;
    cs = 8'h00;
    for (int w = 0; w < nwords; w++) begin
      d = 16'hA500 + 16'(w);
      bytes.push_back(8'(w >> 8));
      bytes.push_back(8'(w));
      bytes.push_back(d[15:8]);
      bytes.push_back(d[7:0]);
    end
    foreach (bytes[i]) cs = cs ^ bytes[i];
    if (CS_BYTES == 1) bytes.push_back(cs);
    for (int i = 0; i < limit && i < bytes.size(); i++) begin
      if (which) exp_q_b.push_back(bytes[i]);
      else       exp_q_a.push_back(bytes[i]);
    end
  endtask

  // One clock: sample and score both DUTs on the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (a_valid && a_ready) begin
      a_bytes++;
      if (exp_q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL a_unexpected_byte: got %02h with empty queue (cycle %0d)", a_byte, cyc);
      end else begin
        e = exp_q_a.pop_front();
        check_eq("a_tx_byte", 32'(a_byte), 32'(e));
      end
    end
    if (b_valid && b_ready) begin
      b_bytes++;
      if (exp_q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected_byte: got %02h with empty queue (cycle %0d)", b_byte, cyc);
      end else begin
        e = exp_q_b.pop_front();
        check_eq("b_tx_byte", 32'(b_byte), 32'(e));
      end
    end
    if (a_stall_prev) begin
      check_eq("a_stall_valid", 32'(a_valid), 32'd1);
      check_eq("a_stall_byte", 32'(a_byte), 32'(a_hold));
    end
    a_stall_prev = a_valid && !a_ready && !rst;
    a_hold       = a_byte;
    b_stall_prev = b_valid && !b_ready && !rst;
    b_hold       = b_byte;
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (a_rd_en && a_first_rd < 0)    a_first_rd = cyc;
    if (a_valid && a_first_valid < 0) a_first_valid = cyc;
    if (b_valid && b_first_valid < 0) b_first_valid = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input int n, input vec_t v);
    int sent0, done0;
    bit aborted;
    sent0   = a_bytes;
    done0   = a_done_cnt;
    aborted = 1'b0;
    push_dump(1'b0, 4, (v.abort_at >= 0) ? v.abort_at + 1 : 4 * 4 + CS_BYTES);
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (v.abort_at >= 0 && !aborted && a_valid && (a_bytes - sent0) == v.abort_at) begin
        a_ready = 1'b0; a_abort = 1'b1; tick();
        a_ready = 1'b1;                 tick();
        a_abort = 1'b0;
        aborted = 1'b1;
      end else begin
        a_ready = (v.ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        tick();
      end
      if (a_done_cnt != done0 || aborted) break;
    end
    a_ready = 1'b1;
    repeat (10) tick();
    $display("case %0d: %0d bytes, %0d done", n, a_bytes - sent0, a_done_cnt - done0);
    check_eq("case_nbytes", 32'(a_bytes - sent0), 32'(v.exp_nbytes));
    check_eq("case_done", 32'(a_done_cnt - done0), 32'(v.exp_done));
    check_eq("case_queue_empty", 32'(exp_q_a.size()), 32'd0);
    check_eq("case_busy_low", 32'(a_busy), 32'd0);
    check_eq("case_addr_zero", 32'(a_addr), 32'd0);
    check_eq("case_state_idle", 32'(a_state), 32'd0);
  endtask

  vec_t vecs[4];
  int c0, done0;

  initial begin
    vecs[0] = '{ready_mode: 0, abort_at: -1, exp_done: 1, exp_nbytes: 16 + CS_BYTES};
    vecs[1] = '{ready_mode: 1, abort_at: -1, exp_done: 1, exp_nbytes: 16 + CS_BYTES};
    vecs[2] = '{ready_mode: 1, abort_at: 5,  exp_done: 0, exp_nbytes: 6};
    vecs[3] = '{ready_mode: 0, abort_at: -1, exp_done: 1, exp_nbytes: 16 + CS_BYTES};

    // Reset state
    repeat (3) tick();
    check_eq("rst_a_rd_en", 32'(a_rd_en), 32'd0);
    check_eq("rst_a_addr", 32'(a_addr), 32'd0);
    check_eq("rst_a_tx_byte", 32'(a_byte), 32'd0);
    check_eq("rst_a_tx_valid", 32'(a_valid), 32'd0);
    check_eq("rst_a_busy", 32'(a_busy), 32'd0);
    check_eq("rst_a_done", 32'(a_done), 32'd0);
    check_eq("rst_b_tx_valid", 32'(b_valid), 32'd0);
    check_eq("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;
    tick();

    // Start-to-first-byte latency, plus a second dump_start while busy that must be ignored
    push_dump(1'b0, 4, 4 * 4 + CS_BYTES);
    done0 = a_done_cnt;
    a_first_rd = -1; a_first_valid = -1;
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    c0 = cyc;
    a_start = 1'b0;
    check_eq("busy_after_start", 32'(a_busy), 32'd1);
    for (int c = 0; c < 200 && a_done_cnt == done0; c++) begin
      a_start = (c == 6);
      tick();
    end
    a_start = 1'b0;
    check_eq("busy_low_after_done", 32'(a_busy), 32'd0);
    check_eq("lat_rd_en", 32'(a_first_rd - c0), 32'd1);
    check_eq("lat_first_valid", 32'(a_first_valid - c0), 32'd3);
    repeat (10) tick();
    check_eq("ignored_start_done", 32'(a_done_cnt - done0), 32'd1);
    check_eq("ignored_start_queue", 32'(exp_q_a.size()), 32'd0);

    // Table-driven dumps: full, stalled, aborted mid-record 2, restart after abort
    for (int i = 0; i < 4; i++) run_case(i, vecs[i]);

    // Reset while a byte is stalled in SEND
    a_ready = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 20 && !a_valid; c++) tick();
    check_eq("rst_send_reached", 32'(a_valid), 32'd1);
    c0 = a_bytes;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_send_valid", 32'(a_valid), 32'd0);
    check_eq("rst_send_busy", 32'(a_busy), 32'd0);
    check_eq("rst_send_byte", 32'(a_byte), 32'd0);
    a_ready = 1'b1;
    repeat (10) tick();
    check_eq("rst_send_no_bytes", 32'(a_bytes - c0), 32'd0);

    // Long dump: 1024 words, RAM latency 3
    push_dump(1'b1, 1024, 4 * 1024 + CS_BYTES);
    b_first_valid = -1;
    done0 = b_done_cnt;
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    c0 = cyc;
    b_start = 1'b0;
    for (int c = 0; c < 12000 && b_done_cnt == done0; c++) tick();
    repeat (5) tick();
    check_eq("b_first_valid", 32'(b_first_valid - c0), 32'd5);
    check_eq("b_done", 32'(b_done_cnt - done0), 32'd1);
    check_eq("b_nbytes", 32'(b_bytes), 32'(4 * 1024 + CS_BYTES));
    check_eq("b_queue_empty", 32'(exp_q_b.size()), 32'd0);
    check_eq("b_busy_low", 32'(b_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
